// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver, configurable frame format,
// with an internal TX->RX loopback path for self-test.
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loopback_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_BRK   = 3'd6;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [2:0]           tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;

  assign tx_ready = (tx_st == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
      unique case (tx_st)
        S_IDLE: begin
          tx_cnt <= '0;
          if (tx_valid) begin
            tx_st    <= S_START;
            tx_sh    <= tx_data;
            tx_par   <= par_bit(tx_data);
            uart_txd <= 1'b0;
          end
        end
        S_START: if (tx_cnt == BIT_END) begin
          tx_st    <= S_DATA;
          tx_cnt   <= '0;
          tx_idx   <= '0;
          uart_txd <= tx_sh[0];
        end
        S_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_sh  <= tx_sh >> 1;
          tx_idx <= tx_idx + BW'(1);
          if (tx_idx != LAST_BIT) begin
            uart_txd <= tx_sh[1];
          end else if (PARITY != 0) begin
            tx_st    <= S_PAR;
            uart_txd <= tx_par;
          end else begin
            tx_st    <= S_STOP;
            uart_txd <= 1'b1;
          end
        end
        S_PAR: if (tx_cnt == BIT_END) begin
          tx_st    <= S_STOP;
          tx_cnt   <= '0;
          uart_txd <= 1'b1;
        end
        S_STOP: if (tx_cnt == STOP_END) begin
          tx_st  <= S_IDLE;
          tx_cnt <= '0;
        end
        default: begin
          tx_st    <= S_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  // RX line: select source, then two flops to tame the async input
  logic       rx_mux;
  logic [1:0] rx_sync;
  logic       line;

  assign rx_mux = loopback_en ? uart_txd : uart_rxd;
  assign line   = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx_mux};
  end

  logic [2:0]           rx_st;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit;

  assign rx_valid = (rx_st == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st         <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_pbit       <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + CW'(1);
      unique case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!line) rx_st <= S_START;
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_idx <= '0;
          rx_st  <= line ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {line, rx_sh[DATA_BITS-1:1]};
          rx_idx <= rx_idx + BW'(1);
          if (rx_idx == LAST_BIT)
            rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (rx_cnt == BIT_END) begin
          rx_cnt  <= '0;
          rx_pbit <= line;
          rx_st   <= S_STOP;
        end
        S_STOP: if (rx_cnt == BIT_END) begin
          rx_data       <= rx_sh;
          rx_parity_err <= (PARITY != 0) && (rx_pbit != par_bit(rx_sh));
          rx_frame_err  <= ~line;
          rx_st         <= S_DONE;
        end
        // a low stop bit means the line may be in break: wait for high
        S_DONE:  rx_st <= rx_frame_err ? S_BRK : S_IDLE;
        S_BRK:   if (line) rx_st <= S_IDLE;
        default: rx_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: three frame formats (8N1, 7E1, 8O2) driven with loopback
// and external frames, checked against a frame-level reference model.
module tb_uart_xcvr;
  localparam int CPB = 16;
  localparam int NI  = 3;

  function automatic int dbits(int k);
    return (k == 1) ? 7 : 8;
  endfunction
  function automatic int pmode(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic int sbits(int k);
    return (k == 2) ? 2 : 1;
  endfunction
  function automatic int flen(int k);
    return 1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k);
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lb[NI], txv[NI], txr[NI], txd[NI], rxd[NI];
  logic       rxv[NI], rxpe[NI], rxfe[NI];
  logic [8:0] txdat[NI], rxdat[NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nrx[NI] = '{0, 0, 0};
  logic [8:0] ld[NI];
  logic       lpe[NI], lfe[NI];
  logic [8:0] hist2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = dbits(g);
    logic [D-1:0] rd;
    uart_xcvr #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(D),
      .PARITY(pmode(g)), .STOP_BITS(sbits(g))
    ) dut (
      .clk(clk), .rst_n(rst_n), .loopback_en(lb[g]),
      .tx_data(txdat[g][D-1:0]), .tx_valid(txv[g]), .tx_ready(txr[g]),
      .uart_txd(txd[g]), .uart_rxd(rxd[g]), .rx_data(rd),
      .rx_valid(rxv[g]), .rx_parity_err(rxpe[g]), .rx_frame_err(rxfe[g])
    );
    assign rxdat[g] = 9'(rd);
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rxv[g] === 1'b1) begin
        nrx[g] <= nrx[g] + 1;
        ld[g]  <= rxdat[g];
        lpe[g] <= rxpe[g];
        lfe[g] <= rxfe[g];
        if (g == 2) hist2.push_back(rxdat[g]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] msk(int k, logic [8:0] d);
    return d & 9'((1 << dbits(k)) - 1);
  endfunction

  function automatic logic mpar(int k, logic [8:0] d);
    logic [8:0] m;
    int ones;
    m = msk(k, d);
    ones = $countones(m);
    return (pmode(k) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Line level for each bit slot of one frame, slot 0 first.
  function automatic logic [15:0] mframe(int k, logic [8:0] d,
                                         bit flip, bit stop);
    logic [15:0] f;
    int p;
    f = '1;
    f[0] = 1'b0;
    p = 1;
    for (int i = 0; i < dbits(k); i++) begin
      f[p] = d[i];
      p++;
    end
    if (pmode(k) != 0) begin
      f[p] = mpar(k, d) ^ flip;
      p++;
    end
    f[p] = stop;
    return f;
  endfunction

  task automatic send(int k, logic [8:0] d, string tag);
    logic [15:0] f;
    int n0, mis, len;
    bit ok;
    f   = mframe(k, d, 1'b0, 1'b1);
    len = flen(k) * CPB;
    n0  = nrx[k];
    lb[k] = 1'b1;
    @(negedge clk);
    txdat[k] = d;
    txv[k]   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (txr[k] === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_acc"}, 32'(ok), 1);
    @(negedge clk);
    txv[k]   = 1'b0;
    txdat[k] = 9'($urandom);
    mis = 0;
    for (int c = 0; c < len; c++) begin
      if (txd[k] !== f[c / CPB]) mis++;
      if (txr[k] !== 1'b0) mis++;
      @(negedge clk);
    end
    chk({tag, "_wave"}, mis, 0);
    chk({tag, "_idle"}, {txr[k], txd[k]}, 2'b11);
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_nrx"}, nrx[k] - n0, 1);
    chk({tag, "_dat"}, ld[k], msk(k, d));
    chk({tag, "_err"}, {lpe[k], lfe[k]}, 2'b00);
  endtask

  task automatic ext(int k, logic [8:0] d, bit flip, bit stop, string tag);
    logic [15:0] f;
    int n0, nb;
    f  = mframe(k, d, flip, stop);
    nb = flen(k) - sbits(k) + 1;
    lb[k]  = 1'b0;
    rxd[k] = 1'b1;
    @(negedge clk);
    n0 = nrx[k];
    for (int c = 0; c < nb * CPB; c++) begin
      rxd[k] = f[c / CPB];
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_nrx"}, nrx[k] - n0, 1);
    chk({tag, "_dat"}, ld[k], msk(k, d));
    chk({tag, "_pe"}, 32'(lpe[k]), 32'(flip && pmode(k) != 0));
    chk({tag, "_fe"}, 32'(lfe[k]), 32'(!stop));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, base;
    int tacc[3];
    bit ok, fl, st;
    logic [8:0] w;
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      lb[g] = 1'b1; txv[g] = 1'b0; txdat[g] = '0; rxd[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_line", {txd[g], txr[g], rxv[g]}, 3'b110);
      chk("rst_rx", {rxdat[g], rxpe[g], rxfe[g]}, 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(0, 9'h0A5, "t1");
    send(1, 9'h055, "t2_lb");
    ext(1, 9'h055, 1'b1, 1'b1, "t2_pe");

    ext(0, 9'h03C, 1'b0, 1'b0, "t3");
    n0 = nrx[0];
    repeat (50 * CPB) @(negedge clk);
    chk("t3_break", nrx[0] - n0, 0);
    rxd[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t3_high", nrx[0] - n0, 0);
    ext(0, 9'h0C3, 1'b0, 1'b1, "t3_rearm");

    n0 = nrx[0];
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("t4_glitch", nrx[0] - n0, 0);
    ext(0, 9'h081, 1'b0, 1'b1, "t4");

    lb[2] = 1'b1;
    base = hist2.size();
    for (int i = 0; i < 3; i++) begin
      txdat[2] = 9'(i + 1);
      txv[2]   = 1'b1;
      ok = 1'b0;
      for (int j = 0; j < 400 && !ok; j++) begin
        if (txr[2] === 1'b1) ok = 1'b1;
        else @(negedge clk);
      end
      chk("t5_acc", 32'(ok), 1);
      tacc[i] = cyc;
      @(negedge clk);
    end
    txv[2] = 1'b0;
    repeat (flen(2) * CPB + 8) @(negedge clk);
    chk("t5_gap1", tacc[1] - tacc[0], flen(2) * CPB + 1);
    chk("t5_gap2", tacc[2] - tacc[1], flen(2) * CPB + 1);
    chk("t5_cnt", hist2.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < hist2.size())
        chk("t5_dat", hist2[base + i], 9'(i + 1));

    lb[0] = 1'b1;
    txdat[0] = 9'h0FF;
    txv[0]   = 1'b1;
    @(negedge clk);
    txv[0] = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    n0 = nrx[0];
    rst_n = 1'b0;
    #1;
    chk("t6_line", {txd[0], txr[0], rxv[0]}, 3'b110);
    chk("t6_rx", {rxdat[0], rxpe[0], rxfe[0]}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * flen(0) * CPB) @(negedge clk);
    chk("t6_norx", nrx[0] - n0, 0);
    send(0, 9'h0F0, "t6");

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 4; i++) begin
        w = 9'($urandom);
        send(k, w, "rnd_lb");
      end
      for (int i = 0; i < 4; i++) begin
        w  = 9'($urandom);
        fl = 1'($urandom);
        st = ($urandom_range(0, 3) != 0);
        ext(k, w, fl, st, "rnd_ext");
        rxd[k] = 1'b1;
        repeat (CPB) @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
